// File: rtl/charmap_writer.sv
// rtl/charmap_writer.sv - console command writer for the character, fg and bg colour RAMs
module charmap_writer #(
    parameter int          COLS   = 40,
    parameter int          ROWS   = 30,
    parameter logic [7:0]  DEF_FG = 8'hFF,
    parameter logic [7:0]  DEF_BG = 8'hC7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [15:0] in_data,
    output logic        chram_wr,
    output logic [11:0] chram_addr,
    output logic [7:0]  chram_data_in,
    output logic [7:0]  fgcolram_data_in,
    output logic [7:0]  bgcolram_data_in,
    output logic        busy,
    output logic [5:0]  cur_x,
    output logic [5:0]  cur_y
);

    localparam logic [5:0]  COL_MAX   = 6'(COLS - 1);
    localparam logic [5:0]  ROW_MAX   = 6'(ROWS - 1);
    localparam logic [11:0] FILL_LAST = {ROW_MAX, COL_MAX};

    localparam logic [1:0] OP_PUT    = 2'd0;
    localparam logic [1:0] OP_SETCUR = 2'd1;
    localparam logic [1:0] OP_SETCOL = 2'd2;
    localparam logic [1:0] OP_FILL   = 2'd3;

    localparam logic [7:0] CH_NEWLINE = 8'h0A;

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cur_x_q, cur_x_d;
    logic [5:0]  cur_y_q, cur_y_d;
    logic [7:0]  fg_q, fg_d;
    logic [7:0]  bg_q, bg_d;
    logic [7:0]  fill_ch_q, fill_ch_d;
    logic [11:0] fill_cnt_q, fill_cnt_d;
    logic        fill_done_q, fill_done_d;
    logic        busy_q, busy_d;
    logic        wr_q, wr_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  ch_q, ch_d;
    logic [7:0]  fgo_q, fgo_d;
    logic [7:0]  bgo_q, bgo_d;

    logic        accept;
    logic [7:0]  cmd_ch;

    // Row advance shared by newline, end-of-line wrap; bottom row wraps to the top (no scroll).
    function automatic logic [5:0] row_next(input logic [5:0] y);
        return (y == ROW_MAX) ? 6'd0 : y + 6'd1;
    endfunction

    // Row-major walk over visible cells only: skip straight from the last column to the next row.
    function automatic logic [11:0] fill_next(input logic [11:0] a);
        if (a[5:0] == COL_MAX) begin
            return {a[11:6] + 6'd1, 6'd0};
        end
        return a + 12'd1;
    endfunction

    assign in_ready = (state_q == S_IDLE) & reset;
    assign accept   = in_valid & in_ready;
    assign cmd_ch   = in_data[7:0];

    assign chram_wr         = wr_q;
    assign chram_addr       = addr_q;
    assign chram_data_in    = ch_q;
    assign fgcolram_data_in = fgo_q;
    assign bgcolram_data_in = bgo_q;
    assign busy             = busy_q;
    assign cur_x            = cur_x_q;
    assign cur_y            = cur_y_q;

    // Next-state: command decode in IDLE, one cell per cycle in FILL; write port registered.
    always_comb begin
        state_d     = state_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        fg_d        = fg_q;
        bg_d        = bg_q;
        fill_ch_d   = fill_ch_q;
        fill_cnt_d  = fill_cnt_q;
        fill_done_d = fill_done_q;
        busy_d      = busy_q;
        wr_d        = 1'b0;
        addr_d      = addr_q;
        ch_d        = ch_q;
        fgo_d       = fgo_q;
        bgo_d       = bgo_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (in_op)
                        OP_PUT: begin
                            if (cmd_ch == CH_NEWLINE) begin
                                cur_x_d = 6'd0;
                                cur_y_d = row_next(cur_y_q);
                            end else begin
                                wr_d   = 1'b1;
                                addr_d = {cur_y_q, cur_x_q};
                                ch_d   = cmd_ch;
                                fgo_d  = fg_q;
                                bgo_d  = bg_q;
                                if (cur_x_q == COL_MAX) begin
                                    cur_x_d = 6'd0;
                                    cur_y_d = row_next(cur_y_q);
                                end else begin
                                    cur_x_d = cur_x_q + 6'd1;
                                end
                            end
                        end
                        OP_SETCUR: begin
                            cur_x_d = (in_data[5:0]  <= COL_MAX) ? in_data[5:0]  : 6'd0;
                            cur_y_d = (in_data[13:8] <= ROW_MAX) ? in_data[13:8] : 6'd0;
                        end
                        OP_SETCOL: begin
                            fg_d = in_data[15:8];
                            bg_d = in_data[7:0];
                        end
                        default: begin
                            // FILL: cell (0,0) is written straight from the acceptance edge
                            // so the first strobe lands one cycle after acceptance.
                            fill_ch_d   = cmd_ch;
                            wr_d        = 1'b1;
                            addr_d      = 12'd0;
                            ch_d        = cmd_ch;
                            fgo_d       = fg_q;
                            bgo_d       = bg_q;
                            fill_cnt_d  = fill_next(12'd0);
                            fill_done_d = (FILL_LAST == 12'd0);
                            busy_d      = 1'b1;
                            state_d     = S_FILL;
                        end
                    endcase
                end
            end
            default: begin
                if (fill_done_q) begin
                    // Final strobe is on the bus this cycle; release the handshake next cycle.
                    state_d     = S_IDLE;
                    busy_d      = 1'b0;
                    fill_done_d = 1'b0;
                    cur_x_d     = 6'd0;
                    cur_y_d     = 6'd0;
                end else begin
                    wr_d   = 1'b1;
                    addr_d = fill_cnt_q;
                    ch_d   = fill_ch_q;
                    fgo_d  = fg_q;
                    bgo_d  = bg_q;
                    if (fill_cnt_q == FILL_LAST) begin
                        fill_done_d = 1'b1;
                    end else begin
                        fill_cnt_d = fill_next(fill_cnt_q);
                    end
                end
            end
        endcase
    end

    // State and output registers; reset aborts any fill in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cur_x_q     <= 6'd0;
            cur_y_q     <= 6'd0;
            fg_q        <= DEF_FG;
            bg_q        <= DEF_BG;
            fill_ch_q   <= 8'd0;
            fill_cnt_q  <= 12'd0;
            fill_done_q <= 1'b0;
            busy_q      <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= 12'd0;
            ch_q        <= 8'd0;
            fgo_q       <= 8'd0;
            bgo_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            fg_q        <= fg_d;
            bg_q        <= bg_d;
            fill_ch_q   <= fill_ch_d;
            fill_cnt_q  <= fill_cnt_d;
            fill_done_q <= fill_done_d;
            busy_q      <= busy_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            ch_q        <= ch_d;
            fgo_q       <= fgo_d;
            bgo_q       <= bgo_d;
        end
    end

endmodule

// File: tb/tb_charmap_writer.sv
// tb/tb_charmap_writer.sv - scoreboard bench for charmap_writer
module tb_charmap_writer;

    localparam int COLS = 40;
    localparam int ROWS = 30;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [15:0] in_data;
    logic        chram_wr;
    logic [11:0] chram_addr;
    logic [7:0]  chram_data_in;
    logic [7:0]  fgcolram_data_in;
    logic [7:0]  bgcolram_data_in;
    logic        busy;
    logic [5:0]  cur_x;
    logic [5:0]  cur_y;

    charmap_writer #(.COLS(COLS), .ROWS(ROWS), .DEF_FG(8'hFF), .DEF_BG(8'hC7)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_op            (in_op),
        .in_data          (in_data),
        .chram_wr         (chram_wr),
        .chram_addr       (chram_addr),
        .chram_data_in    (chram_data_in),
        .fgcolram_data_in (fgcolram_data_in),
        .bgcolram_data_in (bgcolram_data_in),
        .busy             (busy),
        .cur_x            (cur_x),
        .cur_y            (cur_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int wr_count  = 0;
    logic [11:0] last_addr = 12'd0;
    logic [35:0] exp_q[$];

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset && chram_wr) begin
            wr_count++;
            last_addr = chram_addr;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 48'({chram_addr, chram_data_in, fgcolram_data_in, bgcolram_data_in}), 48'hDEAD);
            end else begin
                check("write", 48'({chram_addr, chram_data_in, fgcolram_data_in, bgcolram_data_in}), 48'(exp_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [15:0] data);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = data;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [5:0] r, input logic [5:0] c, input logic [7:0] ch,
                        input logic [7:0] fg, input logic [7:0] bg);
        exp_q.push_back({r, c, ch, fg, bg});
    endtask

    int base;
    int bad_flags;
    int cyc;
    logic saw_ready_low;

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_op    = 2'd0;
        in_data  = 16'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 48'({chram_wr, chram_addr, chram_data_in, fgcolram_data_in, bgcolram_data_in, busy}), 48'd0);
        check("reset_ready", 48'(in_ready), 48'd0);
        check("reset_cursor", 48'({cur_y, cur_x}), 48'd0);
        reset = 1'b1;
        #1;
        check("ready_after_release", 48'(in_ready), 48'd1);

        // PUT 'A' at origin with default colours
        base = wr_count;
        push(6'd0, 6'd0, 8'h41, 8'hFF, 8'hC7);
        send(2'd0, 16'h0041);
        check("put_cur_x", 48'(cur_x), 48'd1);
        @(negedge clk); #2;
        check("put_one_write", 48'(wr_count - base), 48'd1);

        // Bottom-right corner wraps to origin
        send(2'd1, {2'b00, 6'd29, 2'b00, 6'd39});
        check("setcur_corner", 48'({cur_y, cur_x}), 48'({6'd29, 6'd39}));
        push(6'd29, 6'd39, 8'h42, 8'hFF, 8'hC7);
        send(2'd0, 16'h0042);
        check("corner_wrap", 48'({cur_y, cur_x}), 48'd0);
        @(negedge clk); #2;
        check("corner_addr", 48'(last_addr), 48'h767);

        // Out-of-range column clamps to 0; newline does not write
        send(2'd1, {2'b00, 6'd5, 2'b00, 6'd50});
        check("setcur_oob", 48'({cur_y, cur_x}), 48'({6'd5, 6'd0}));
        base = wr_count;
        send(2'd0, 16'h000A);
        repeat (2) @(negedge clk); #2;
        check("newline_no_write", 48'(wr_count - base), 48'd0);
        check("newline_cursor", 48'({cur_y, cur_x}), 48'({6'd6, 6'd0}));

        // SETCOL then PUT back-to-back
        @(negedge clk);
        check("ready_before_setcol", 48'(in_ready), 48'd1);
        in_valid = 1'b1; in_op = 2'd2; in_data = 16'h07C0;
        @(posedge clk); #1;
        push(6'd6, 6'd0, 8'h20, 8'h07, 8'hC0);
        check("ready_back_to_back", 48'(in_ready), 48'd1);
        in_op = 2'd0; in_data = 16'h0020;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("setcol_put_cursor", 48'({cur_y, cur_x}), 48'({6'd6, 6'd1}));
        @(negedge clk); #2;
        check("setcol_put_drained", 48'(exp_q.size()), 48'd0);

        // Full-window FILL
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                push(6'(r), 6'(c), 8'h2E, 8'h07, 8'hC0);
        base = wr_count;
        bad_flags = 0;
        send(2'd3, 16'h002E);
        cyc = 0;
        saw_ready_low = 1'b0;
        forever begin
            @(negedge clk); #2;
            cyc++;
            if (in_ready) break;
            saw_ready_low = 1'b1;
            if (chram_wr && !busy) bad_flags++;
            if (cyc > 1400) break;
        end
        check("fill_terminates", 48'(cyc <= 1400), 48'd1);
        check("fill_ready_low_seen", 48'(saw_ready_low), 48'd1);
        check("fill_strobes", 48'(wr_count - base), 48'd1200);
        check("fill_cycles", 48'(cyc), 48'd1201);
        check("fill_busy_during", 48'(bad_flags), 48'd0);
        check("fill_last_addr", 48'(last_addr), 48'h767);
        check("fill_busy_after", 48'(busy), 48'd0);
        check("fill_cursor_after", 48'({cur_y, cur_x}), 48'd0);
        check("fill_drained", 48'(exp_q.size()), 48'd0);

        // Reset aborts a fill after 100 writes
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                push(6'(r), 6'(c), 8'h55, 8'h07, 8'hC0);
        base = wr_count;
        send(2'd3, 16'h0055);
        cyc = 0;
        while ((wr_count - base) < 100 && cyc < 200) begin
            @(negedge clk); #2;
            cyc++;
        end
        check("abort_reached_100", 48'(wr_count - base), 48'd100);
        reset = 1'b0;
        #1;
        check("abort_wr_drops", 48'(chram_wr), 48'd0);
        check("abort_busy", 48'(busy), 48'd0);
        check("abort_ready", 48'(in_ready), 48'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_ready_release", 48'(in_ready), 48'd1);
        check("abort_cursor", 48'({cur_y, cur_x}), 48'd0);
        push(6'd0, 6'd0, 8'h61, 8'hFF, 8'hC7);
        base = wr_count;
        send(2'd0, 16'h0061);
        @(negedge clk); #2;
        check("abort_put_write", 48'(wr_count - base), 48'd1);
        check("abort_drained", 48'(exp_q.size()), 48'd0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/charmap_writer.md
Name: charmap_writer

Overview:
- Write-side companion to the character-map renderer. Accepts a stream of console commands over a valid/ready handshake and writes character codes plus foreground and background colours into the three 64x64 character RAMs.
- The RAMs are character, fg colour and bg colour, all addressed {row[5:0], col[5:0]}.
- Maintains a text cursor within a visible COLS x ROWS window. Supports put-char, newline, cursor positioning, colour selection and full-window fill.
- Sits between the CPU-side / test-pattern command source and the write ports of the character, fg and bg RAMs.

Parameters:
- COLS, 40, visible columns (1..64).
- ROWS, 30, visible rows (1..64).
- DEF_FG, 8'hFF, foreground colour after reset (BBGGGRRR).
- DEF_BG, 8'hC7, background colour after reset; this value is the renderer's transparent key.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  command valid.
- in_ready  out  1  block can accept a command this cycle.
- in_op  in  2  opcode: 0 PUT, 1 SETCUR, 2 SETCOL, 3 FILL.
- in_data  in  16  operand.
- chram_wr  out  1  write strobe, common to all three RAMs.
- chram_addr  out  12  write address {row, col}.
- chram_data_in  out  8  character code.
- fgcolram_data_in  out  8  foreground colour.
- bgcolram_data_in  out  8  background colour.
- busy  out  1  FILL in progress.
- cur_x  out  6  current cursor column.
- cur_y  out  6  current cursor row.

Behaviour:
- **Reset (reset=0, asynchronous):**
  - state=IDLE; cur_x=cur_y=0; fg=DEF_FG; bg=DEF_BG.
  - chram_wr=0; chram_addr=0; all data outputs 0; busy=0.
  - in_ready=0 while reset is asserted.
  - A reset during FILL aborts the fill immediately. Cells already written stay written.
- **Handshake:**
  - in_ready = (state==IDLE) & reset.
  - A command is accepted on a rising edge where in_valid & in_ready.
  - No buffering: in_ready is low in every state other than IDLE.
- **Outputs:** all write-port outputs are registered. A write strobe appears exactly one cycle after acceptance and lasts one cycle per cell.
- **States:** IDLE, FILL. PUT, SETCUR and SETCOL complete in the acceptance cycle, so the block stays in IDLE and back-to-back commands are accepted every cycle.
- **PUT (in_data[7:0]=c):**
  - c==8'h0A (newline): no write. cur_x<=0; cur_y<=(cur_y==ROWS-1)?0:cur_y+1.
  - Otherwise: next cycle chram_wr=1, addr={cur_y,cur_x}, chram_data_in=c, fg/bg = current colours.
  - Cursor advance: cur_x+1. At cur_x==COLS-1, cur_x<=0 and cur_y advances with the same wrap as newline.
  - (COLS-1, ROWS-1) therefore wraps to (0,0). No scrolling.
- **SETCUR:**
  - col=in_data[5:0], row=in_data[13:8].
  - Each axis is loaded only if in range (col<COLS, row<ROWS); an out-of-range axis is set to 0.
  - No write.
- **SETCOL:** fg<=in_data[15:8]; bg<=in_data[7:0]. Takes effect for the next accepted PUT or FILL. No write.
- **FILL (in_data[7:0]=c):**
  - Latches c, fg and bg, then enters FILL with busy=1.
  - Writes one cell per cycle, row-major from (0,0) to (COLS-1, ROWS-1): COLS*ROWS consecutive chram_wr cycles, the first one cycle after acceptance.
  - Only visible cells are written; addresses with col>=COLS are never produced.
  - After the last write: state=IDLE, busy=0, cur_x=cur_y=0. in_ready rises the cycle after the final strobe.
  - Newline code 0x0A is written literally during FILL.
- **Simultaneous events:** none are possible, because only one command is accepted per cycle. If an accepted PUT follows a SETCOL in the next cycle, the PUT uses the new colours.
- **Widths:** cursor registers are 6 bits. Comparisons use COLS-1 and ROWS-1 as 6-bit constants. The FILL counter is 12 bits, {row, col}.

Test Plan:
- Reset release, then PUT 0x41 -> the next cycle has chram_wr=1, addr=12'h000, data 0x41, fg 0xFF, bg 0xC7; cur_x=1.
- SETCUR col=39 row=29, then PUT 0x42 -> write at addr {6'd29,6'd39}=12'h767; cursor wraps to (0,0).
- SETCUR col=50 row=5 -> cur_x=0, cur_y=5. Then PUT 0x0A -> no chram_wr, cursor (0,6).
- SETCOL 16'h07C0, then PUT 0x20 with no gap -> write shows fg=0x07, bg=0xC0. Back-to-back acceptance holds in_ready=1 throughout.
- FILL 0x2E -> exactly 1200 strobes; the first at addr 0x000, the 40th at 0x027, the 41st at 0x040, the last at 0x767. busy=1 and in_ready=0 for the duration; afterwards cursor (0,0).
- Assert reset after 100 FILL writes -> chram_wr drops immediately, busy=0, colours return to defaults. After release, in_ready=1 and the next PUT writes addr 0.
